// File: rtl/sa_output_drain_if.sv
// Handshake/data bundle between the systolic-array bottom row, the output drain and its consumer.
interface sa_output_drain_if #(
  parameter int ACCUMULATE_WIDTH = 16,
  parameter int COLS             = 4,
  parameter int DEPTH            = 4
);
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  logic                             clear_i;
  logic                             in_valid_i;
  logic [COLS*ACCUMULATE_WIDTH-1:0] c_i;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic [COLS*ACCUMULATE_WIDTH-1:0] out_row_o;
  logic [COUNT_W-1:0]               count_o;
  logic                             overflow_o;

  modport master (
    output clear_i, in_valid_i, c_i, out_ready_i,
    input  out_valid_o, out_row_o, count_o, overflow_o
  );

  modport slave (
    input  clear_i, in_valid_i, c_i, out_ready_i,
    output out_valid_o, out_row_o, count_o, overflow_o
  );
endinterface

// File: rtl/sa_output_drain.sv
// Deskews the staggered column results of a systolic array into whole rows and
// buffers them in a small FIFO; the array cannot stall, so a full FIFO drops rows.
module sa_output_drain #(
  parameter int ACCUMULATE_WIDTH = 16,
  parameter int COLS             = 4,
  parameter int DEPTH            = 4
) (
  input logic                clk_i,
  input logic                reset,
  sa_output_drain_if.slave   bus
);
  localparam int W       = ACCUMULATE_WIDTH;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  logic [COLS*W-1:0]  aligned_row;
  logic [COLS-2:0]    valid_dly;
  logic               push;
  logic               pop;
  logic               full;
  logic               accept;
  logic               drop;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_next;
  logic               overflow;
  logic [COLS*W-1:0]  mem [DEPTH];

  // Column j arrives j cycles after column 0, so it is held back COLS-1-j cycles.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned_row[j*W +: W] = bus.c_i[j*W +: W];
    end else begin : g_dly
      logic [W-1:0] stage [D];
      // NOTE: pure data pipeline, no reset; stale contents are harmless because
      // the valid shift register (which is reset) decides whether they are used.
      always_ff @(posedge clk_i) begin
        stage[0] <= bus.c_i[j*W +: W];
        for (int k = 1; k < D; k++) stage[k] <= stage[k-1];
      end
      assign aligned_row[j*W +: W] = stage[D-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, giving a true shift.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) valid_dly <= '0;
    else if (COLS > 2) valid_dly <= {valid_dly[COLS-3:0], bus.in_valid_i};
    else valid_dly <= bus.in_valid_i;
  end

  assign push   = valid_dly[COLS-2];
  assign full   = (count == COUNT_W'(DEPTH));
  assign pop    = (count != '0) && bus.out_ready_i;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // NOTE: default assigned first so no path through this block infers a latch.
  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // A drop outranks a coincident clear so no lost row goes unreported.
      if (drop)             overflow <= 1'b1;
      else if (bus.clear_i) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= aligned_row;
  end

  assign bus.out_valid_o = (count != '0);
  assign bus.out_row_o   = mem[rd_ptr];
  assign bus.count_o     = count;
  assign bus.overflow_o  = overflow;
endmodule

// File: tb/tb_sa_output_drain.sv
// Directed bench for sa_output_drain (COLS=4, DEPTH=4, 16-bit columns).
module tb_sa_output_drain;
  logic clk_i = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sa_output_drain_if #(.ACCUMULATE_WIDTH(16), .COLS(4), .DEPTH(4)) bus ();

  sa_output_drain #(.ACCUMULATE_WIDTH(16), .COLS(4), .DEPTH(4)) dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Row r of a burst: column j carries base + 16*r + j.
  function automatic logic [63:0] exp_row(input logic [15:0] base, input int r);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = base + 16'(16*r + j);
    return v;
  endfunction

  // Skewed stimulus for step k of an n-row burst: column j carries row k-j.
  task automatic drive(input int k, input int n, input logic [15:0] base);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 4; j++)
      if (k - j >= 0 && k - j < n) v[j*16 +: 16] = base + 16'(16*(k-j) + j);
    bus.in_valid_i = (k < n);
    bus.c_i        = v;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
    bus.c_i        = '0;
    bus.clear_i    = 1'b0;
  endtask

  initial begin
    idle();
    bus.out_ready_i = 1'b0;
    tick();
    tick();
    check("reset_valid", 64'(bus.out_valid_o), 64'd0);
    check("reset_count", 64'(bus.count_o), 64'd0);
    check("reset_ovf", 64'(bus.overflow_o), 64'd0);
    reset = 1'b0;

    // Ready while empty does nothing.
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    check("empty_ready_count", 64'(bus.count_o), 64'd0);

    // Single row, latency COLS-1, popped next edge.
    for (int k = 0; k < 4; k++) begin
      drive(k, 1, 16'h0100);
      tick();
      if (k == 2) check("single_not_yet", 64'(bus.out_valid_o), 64'd0);
    end
    check("single_valid", 64'(bus.out_valid_o), 64'd1);
    check("single_row", bus.out_row_o, 64'h0103_0102_0101_0100);
    check("single_count", 64'(bus.count_o), 64'd1);
    idle();
    tick();
    check("single_popped", 64'(bus.count_o), 64'd0);
    check("single_valid_low", 64'(bus.out_valid_o), 64'd0);

    // Six rows into a 4-deep FIFO with no consumer.
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(k, 6, 16'h0000);
      tick();
      if (k == 6) begin
        check("fill_count4", 64'(bus.count_o), 64'd4);
        check("fill_no_ovf", 64'(bus.overflow_o), 64'd0);
      end
      if (k == 7) begin
        check("drop_count", 64'(bus.count_o), 64'd4);
        check("drop_ovf", 64'(bus.overflow_o), 64'd1);
      end
    end
    idle();
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_row%0d", i), bus.out_row_o, exp_row(16'h0000, i));
      tick();
    end
    bus.out_ready_i = 1'b0;
    check("drain_empty", 64'(bus.count_o), 64'd0);
    check("drain_ovf_sticky", 64'(bus.overflow_o), 64'd1);

    // Clear with no drop.
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    check("clear_ovf", 64'(bus.overflow_o), 64'd0);

    // Full FIFO, push coincident with pop is accepted.
    for (int k = 0; k < 8; k++) begin
      drive(k, 5, 16'h1000);
      bus.out_ready_i = (k == 7);
      tick();
      if (k == 6) check("full_count", 64'(bus.count_o), 64'd4);
    end
    idle();
    bus.out_ready_i = 1'b0;
    check("pushpop_count", 64'(bus.count_o), 64'd4);
    check("pushpop_ovf", 64'(bus.overflow_o), 64'd0);
    check("pushpop_head", bus.out_row_o, exp_row(16'h1000, 1));

    // Clear coincident with a drop: drop wins.
    for (int k = 0; k < 4; k++) begin
      drive(k, 1, 16'h2000);
      bus.clear_i = (k == 3);
      tick();
    end
    idle();
    check("clear_vs_drop_ovf", 64'(bus.overflow_o), 64'd1);
    check("clear_vs_drop_count", 64'(bus.count_o), 64'd4);
    check("clear_vs_drop_head", bus.out_row_o, exp_row(16'h1000, 1));
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    check("clear2_ovf", 64'(bus.overflow_o), 64'd0);
    bus.out_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("drain2_row%0d", i), bus.out_row_o, exp_row(16'h1000, i));
      tick();
    end
    check("drain2_empty", 64'(bus.count_o), 64'd0);

    // Streaming: 20 back-to-back rows with an always-ready consumer.
    for (int k = 0; k < 23; k++) begin
      drive(k, 20, 16'h4000);
      tick();
      if (k >= 3) begin
        check($sformatf("stream_row%0d", k-3), bus.out_row_o, exp_row(16'h4000, k-3));
        check($sformatf("stream_count%0d", k-3), 64'(bus.count_o), 64'd1);
      end
    end
    idle();
    tick();
    check("stream_empty", 64'(bus.count_o), 64'd0);
    check("stream_ovf", 64'(bus.overflow_o), 64'd0);

    // Mid-cycle reset with two rows buffered and one in the deskew pipeline.
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(k, 3, 16'h5000);
      tick();
    end
    idle();
    check("prereset_count", 64'(bus.count_o), 64'd2);
    #3 reset = 1'b1;
    #1;
    check("areset_valid", 64'(bus.out_valid_o), 64'd0);
    check("areset_count", 64'(bus.count_o), 64'd0);
    check("areset_ovf", 64'(bus.overflow_o), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("postreset_valid%0d", i), 64'(bus.out_valid_o), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sa_output_drain.md
SA_OUTPUT_DRAIN -- requirements
Module: sa_output_drain

Interface
REQ-001 The block SHALL have parameter ACCUMULATE_WIDTH, default 16, giving the bit width of one column result.
REQ-002 The block SHALL have parameter COLS, default 4 (min 2), giving the number of array columns drained.
REQ-003 The block SHALL have parameter DEPTH, default 4 (power of 2, min 2), giving the output FIFO depth in rows.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear_i  input  1  synchronous clear of the overflow flag only.
REQ-007 in_valid_i  input  1  column 0 result present on c_i this cycle; column j result for the same row follows j cycles later.
REQ-008 c_i  input  COLS*ACCUMULATE_WIDTH  column results from the bottom array row, column j at bits [j*ACCUMULATE_WIDTH +: ACCUMULATE_WIDTH].
REQ-009 out_valid_o  output  1  aligned row available on out_row_o.
REQ-010 out_ready_i  input  1  consumer accepts the row when high together with out_valid_o.
REQ-011 out_row_o  output  COLS*ACCUMULATE_WIDTH  aligned row, same column packing as c_i.
REQ-012 count_o  output  $clog2(DEPTH)+1  FIFO occupancy in rows, 0..DEPTH.
REQ-013 overflow_o  output  1  sticky: at least one aligned row was dropped because the FIFO was full.

Function
REQ-014 The block SHALL delay column j of c_i by COLS-1-j cycles so all columns of one row are aligned; column COLS-1 has zero delay.
REQ-015 in_valid_i SHALL be delayed COLS-1 cycles by a valid shift register; its output is the push strobe for the aligned row.
REQ-016 The aligned row SHALL be written to the FIFO on the edge at which the push strobe is high, i.e. COLS-1 edges after the edge sampling in_valid_i=1.
REQ-017 Back-to-back in_valid_i (every cycle) SHALL produce one push per cycle with no row loss while the FIFO has space.
REQ-018 The upstream array cannot stall; the block SHALL NOT back-pressure the input.
REQ-019 A pop SHALL occur on an edge where out_valid_o=1 and out_ready_i=1; out_row_o SHALL show the oldest row, registered, with no combinational path from c_i or out_ready_i.
REQ-020 out_valid_o SHALL equal (count_o != 0); a pushed row is visible the cycle after its push edge (no bypass).
REQ-021 Push and pop on the same edge SHALL both take effect; count_o unchanged.
REQ-022 Push while count_o=DEPTH and no simultaneous pop SHALL drop the row, leave FIFO contents and count unchanged, and set overflow_o on that edge.
REQ-023 Push while count_o=DEPTH with simultaneous pop SHALL be accepted; overflow_o not set.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH nor underflow.
REQ-025 out_ready_i while out_valid_o=0 SHALL have no effect.
REQ-026 clear_i SHALL clear overflow_o on the next edge; a drop on the same edge SHALL win (overflow_o stays 1).
REQ-027 Data values SHALL pass through unmodified; no arithmetic on results.

Reset
REQ-028 reset high SHALL asynchronously force count_o=0, out_valid_o=0, overflow_o=0, pointers=0 and all valid-delay bits=0.
REQ-029 Rows in flight in the deskew pipeline at reset SHALL be discarded; column data registers need not be reset; out_row_o is don't-care while out_valid_o=0.
REQ-030 The first edge after reset deassertion SHALL sample inputs normally.

Verification
REQ-031 COLS=4: in_valid_i=1 at edge 0, column j value 0x0100+j at edge j, out_ready_i=1 -> out_valid_o=1 after edge 3, out_row_o={0x0103,0x0102,0x0101,0x0100}, count_o=1, popped at edge 4.
REQ-032 Six consecutive skewed rows (row r column j = 16*r+j), out_ready_i=0, DEPTH=4 -> count_o=4, overflow_o=1 after the 5th push, then draining yields rows 0..3 in order.
REQ-033 FIFO full, out_ready_i=1 on the push edge -> row accepted, count_o stays 4, overflow_o stays 0.
REQ-034 Continuous rows for 20 cycles, out_ready_i=1 -> 20 rows out in order, count_o<=1, overflow_o=0, pointers wrap.
REQ-035 reset asserted mid-clock with 2 rows in FIFO and 1 in deskew -> outputs 0 immediately; no row emitted after release without new input.
REQ-036 overflow_o=1, clear_i=1 with no drop -> overflow_o=0 next edge; clear_i=1 coincident with a drop -> overflow_o=1.
